// File: rtl/ddc_capture_ctrl_if.sv
// Avalon-MM slave port bundle for the DDC capture controller.
// Carries the register bus signals and the level interrupt.
interface ddc_capture_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, read, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, read, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/ddc_capture_ctrl.sv
// Triggered DDC sample capture: arms on a CPU write, fires on a rising threshold crossing,
// stores POST samples and drains them over Avalon-MM. Optional timestamp: DDC_CAPTURE_TSTAMP_EN.
module ddc_capture_ctrl #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 14
) (
  input  logic                clk,
  input  logic                reset,
  ddc_capture_ctrl_if.slave   bus,
  input  logic [DATA_W-1:0]   in_port
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] d1, d2, thresh;
  logic [10:0]       post;
  logic              irq_mask, done_flag;
  logic [LW-1:0]     level, n_tgt, n_live;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [31:0]       tstamp, rd_mux, readdata_q;

  logic wr_en, rd_en, ctrl_wr, do_abort, arm_req, do_clear;
  logic trigger, trig_fire, pop, buf_we, flush, set_done;
  logic unused_bits;

  assign wr_en    = bus.chipselect & ~bus.write_n;
  assign rd_en    = bus.chipselect & bus.read;
  assign ctrl_wr  = wr_en && (bus.address == 3'd0);
  assign do_abort = ctrl_wr & bus.writedata[1];
  assign arm_req  = ctrl_wr & bus.writedata[0] & ~bus.writedata[1];
  assign do_clear = ctrl_wr & bus.writedata[2];
  assign unused_bits = ^bus.writedata;

  // Rising crossing only: a level held above threshold never fires.
  assign trigger   = (d1 >= thresh) && (d2 < thresh);
  assign trig_fire = (state == S_ARMED) && trigger && !do_abort;
  assign n_live    = ((post == 11'd0) || (post > 11'(DEPTH))) ? LW'(DEPTH) : LW'(post);
  assign pop       = rd_en && (bus.address == 3'd3) && (state == S_DONE) && (level != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    if (do_abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (arm_req) state_nxt = S_ARMED;
        S_ARMED:   if (trigger) state_nxt = (n_live == LW'(1)) ? S_DONE : S_CAPTURE;
        S_CAPTURE: if (level + LW'(1) == n_tgt) state_nxt = S_DONE;
        S_DONE:    if (arm_req) state_nxt = S_ARMED;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    flush    = do_abort || (arm_req && ((state == S_IDLE) || (state == S_DONE)));
    buf_we   = trig_fire || ((state == S_CAPTURE) && !do_abort);
    set_done = (state != S_DONE) && (state_nxt == S_DONE);
  end

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      3'd0:    rd_mux = {29'd0, done_flag, state};
      3'd1:    rd_mux = 32'(thresh);
      3'd2:    rd_mux = 32'(post);
      3'd3:    rd_mux = pop ? 32'(mem[rd_ptr]) : 32'd0;
      3'd4:    rd_mux = {31'd0, irq_mask};
      3'd5:    rd_mux = 32'(level);
      3'd6:    rd_mux = tstamp;
      default: rd_mux = '0;
    endcase
  end

  // NOTE: sample storage has no reset; occupancy is tracked by the pointers and level alone.
  always_ff @(posedge clk) begin
    if (buf_we) mem[wr_ptr] <= d1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d1         <= '0;
      d2         <= '0;
      thresh     <= '0;
      post       <= '0;
      irq_mask   <= 1'b0;
      done_flag  <= 1'b0;
      n_tgt      <= '0;
      level      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      readdata_q <= '0;
    end else begin
      d1 <= in_port;
      d2 <= d1;
      if (wr_en) begin
        case (bus.address)
          3'd1:    thresh   <= bus.writedata[DATA_W-1:0];
          3'd2:    post     <= bus.writedata[10:0];
          3'd4:    irq_mask <= bus.writedata[0];
          default: ;
        endcase
      end
      // Sample count is frozen at the trigger so mid-capture POST writes wait for the next arm.
      if (trig_fire) n_tgt <= n_live;
      if (flush) begin
        level  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else if (buf_we) begin
        level  <= level + LW'(1);
        wr_ptr <= wr_ptr + AW'(1);
      end else if (pop) begin
        level  <= level - LW'(1);
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (flush || do_clear) done_flag <= 1'b0;
      if (set_done)          done_flag <= 1'b1;
      if (rd_en)             readdata_q <= rd_mux;
    end
  end

`ifdef DDC_CAPTURE_TSTAMP_EN
  logic [31:0] ts_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_cnt <= '0;
      tstamp <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (trig_fire) tstamp <= ts_cnt;
    end
  end
`else
  assign tstamp = '0;
`endif

  assign bus.readdata = readdata_q;
  assign bus.irq      = done_flag & irq_mask;

endmodule

// File: tb/tb_ddc_capture_ctrl.sv
// Directed bench for ddc_capture_ctrl: threshold trigger, readout, irq, abort, POST
// boundaries, mid-capture reset and the optional timestamp.
module tb_ddc_capture_ctrl;
  localparam int DEPTH  = 64;
  localparam int DATA_W = 14;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [DATA_W-1:0] in_port = '0;
  logic [31:0]       rd;
  int                n_checks = 0;
  int                n_fail = 0;
  int                cyc;
  int                exp_ts;

  ddc_capture_ctrl_if bus();

  ddc_capture_ctrl #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .in_port (in_port)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the timestamp counter should track this exactly.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] addr, input logic [31:0] data);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = addr;
    bus.writedata  = data;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic rd_reg(input logic [2:0] addr, output logic [31:0] val);
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.address    = addr;
    tick();
    val            = bus.readdata;
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
  endtask

  task automatic ramp(input int lo, input int hi);
    for (int v = lo; v <= hi; v++) begin
      in_port = DATA_W'(v);
      tick();
    end
  endtask

  initial begin
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.read       = 1'b0;
    bus.address    = '0;
    bus.writedata  = '0;

    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check("rst_readdata", bus.readdata, 32'd0);
    check("rst_irq", {31'd0, bus.irq}, 32'd0);
    rd_reg(3'd0, rd); check("rst_ctrl", rd, 32'd0);
    rd_reg(3'd1, rd); check("rst_thresh", rd, 32'd0);
    rd_reg(3'd2, rd); check("rst_post", rd, 32'd0);
    rd_reg(3'd4, rd); check("rst_irq_mask", rd, 32'd0);
    rd_reg(3'd5, rd); check("rst_level", rd, 32'd0);
    rd_reg(3'd6, rd); check("rst_tstamp", rd, 32'd0);

    // Ramp through THRESH=100 with POST=4
    wr(3'd1, 32'd100);
    wr(3'd2, 32'd4);
    rd_reg(3'd1, rd); check("thresh_rb", rd, 32'd100);
    in_port = DATA_W'(96);
    tick(2);
    wr(3'd0, 32'd1);
    rd_reg(3'd0, rd); check("armed_ctrl", rd, 32'd1);
    ramp(97, 110);
    rd_reg(3'd0, rd); check("post4_ctrl", rd, 32'd7);
    rd_reg(3'd5, rd); check("post4_level", rd, 32'd4);
    check("post4_irq_masked", {31'd0, bus.irq}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      rd_reg(3'd3, rd); check($sformatf("post4_data%0d", i), rd, 32'(100 + i));
    end
    rd_reg(3'd3, rd); check("post4_empty_data", rd, 32'd0);
    rd_reg(3'd5, rd); check("post4_level_end", rd, 32'd0);

    // Interrupt mask and done clear
    wr(3'd4, 32'd1);
    check("irq_on_mask", {31'd0, bus.irq}, 32'd1);
    wr(3'd0, 32'd4);
    check("irq_cleared", {31'd0, bus.irq}, 32'd0);
    rd_reg(3'd0, rd); check("clear_ctrl", rd, 32'd3);
    in_port = DATA_W'(96);
    tick(2);
    wr(3'd0, 32'd1);
    check("irq_after_arm", {31'd0, bus.irq}, 32'd0);
    ramp(97, 110);
    check("irq_done", {31'd0, bus.irq}, 32'd1);
    wr(3'd0, 32'd4);
    check("irq_clear2", {31'd0, bus.irq}, 32'd0);

    // POST=0 captures the full DEPTH and drains with a pointer wrap
    wr(3'd2, 32'd0);
    in_port = DATA_W'(90);
    tick(2);
    wr(3'd0, 32'd1);
    ramp(91, 200);
    rd_reg(3'd0, rd); check("full_ctrl", rd, 32'd7);
    rd_reg(3'd5, rd); check("full_level", rd, 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      rd_reg(3'd3, rd); check($sformatf("full_data%0d", i), rd, 32'(100 + i));
    end
    rd_reg(3'd3, rd); check("full_empty_data", rd, 32'd0);
    rd_reg(3'd5, rd); check("full_level_end", rd, 32'd0);

    // Abort mid-capture, ignored re-arm, arm+abort
    wr(3'd2, 32'd20);
    in_port = DATA_W'(96);
    tick(2);
    wr(3'd0, 32'd1);
    ramp(97, 105);
    rd_reg(3'd0, rd); check("cap_ctrl", rd, 32'd2);
    rd_reg(3'd3, rd); check("cap_data_zero", rd, 32'd0);
    wr(3'd0, 32'd1);
    rd_reg(3'd0, rd); check("cap_rearm_ignored", rd, 32'd2);
    wr(3'd0, 32'd2);
    rd_reg(3'd0, rd); check("abort_ctrl", rd, 32'd0);
    rd_reg(3'd5, rd); check("abort_level", rd, 32'd0);
    check("abort_irq", {31'd0, bus.irq}, 32'd0);
    wr(3'd0, 32'd1);
    rd_reg(3'd0, rd); check("rearm_ctrl", rd, 32'd1);
    wr(3'd0, 32'd3);
    rd_reg(3'd0, rd); check("arm_abort_ctrl", rd, 32'd0);

    // Held level gives no trigger; fall then rise does. POST=1 completes on the trigger cycle.
    wr(3'd2, 32'd1);
    in_port = DATA_W'(200);
    tick(3);
    wr(3'd0, 32'd1);
    tick(10);
    rd_reg(3'd0, rd); check("held_no_trig", rd, 32'd1);
    in_port = DATA_W'(50);
    tick(3);
    rd_reg(3'd0, rd); check("low_no_trig", rd, 32'd1);
    in_port = DATA_W'(150);
    // 150 reaches d1 on the next edge; the trigger edge latches the counter one edge later.
    exp_ts = cyc + 1;
    tick(3);
    rd_reg(3'd0, rd); check("rise_ctrl", rd, 32'd7);
    rd_reg(3'd5, rd); check("rise_level", rd, 32'd1);
    rd_reg(3'd6, rd);
`ifdef DDC_CAPTURE_TSTAMP_EN
    check("tstamp", rd, 32'(exp_ts));
`else
    check("tstamp_off", rd, 32'd0);
`endif
    rd_reg(3'd3, rd); check("rise_data", rd, 32'd150);
    rd_reg(3'd5, rd); check("rise_level_end", rd, 32'd0);

    // Reset mid-capture discards everything
    wr(3'd2, 32'd20);
    in_port = DATA_W'(96);
    tick(2);
    wr(3'd0, 32'd1);
    ramp(97, 104);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd_reg(3'd0, rd); check("mid_rst_ctrl", rd, 32'd0);
    rd_reg(3'd5, rd); check("mid_rst_level", rd, 32'd0);
    rd_reg(3'd1, rd); check("mid_rst_thresh", rd, 32'd0);
    check("mid_rst_irq", {31'd0, bus.irq}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ddc_capture_ctrl.md
DDC_CAPTURE_CTRL -- requirements
Module: ddc_capture_ctrl

Interface
REQ-001 Parameter DEPTH, default 64, meaning: capture buffer depth in samples (power of two, 16..1024).
REQ-002 Parameter DATA_W, default 14, meaning: sample width.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 address  input  3  Avalon-MM word address.
REQ-006 chipselect  input  1  slave select.
REQ-007 write_n  input  1  active-low write strobe.
REQ-008 read  input  1  active-high read strobe.
REQ-009 writedata  input  32  write data.
REQ-010 readdata  output  32  registered read data, 1-cycle latency, unused bits zero.
REQ-011 in_port  input  DATA_W  raw DDC sample, asynchronous to clk.
REQ-012 irq  output  1  level interrupt = done_flag & irq_mask.

Function
REQ-013 The block SHALL double-register in_port (d1, d2) and use only the registered values.
REQ-014 Register map SHALL be: 0 CTRL, 1 THRESH[DATA_W-1:0], 2 POST[10:0], 3 DATA (pop), 4 IRQ_MASK[0], 5 LEVEL[10:0], 6 TSTAMP.
REQ-015 A CTRL write SHALL decode bit0 = arm, bit1 = abort, bit2 = clear done_flag.
REQ-016 A CTRL read SHALL return {state[1:0] in bits 1:0, done_flag in bit 2}.
REQ-017 The FSM SHALL have states IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
REQ-018 Arm in IDLE or DONE SHALL flush the buffer, clear done_flag and enter ARMED next cycle.
REQ-019 Arm in ARMED or CAPTURE SHALL be ignored.
REQ-020 In ARMED, the trigger SHALL fire when d1 >= THRESH and d2 < THRESH (unsigned rising crossing), entering CAPTURE.
REQ-021 On the trigger cycle, the trigger sample d1 SHALL be written as buffer entry 0.
REQ-022 Each subsequent CAPTURE cycle SHALL write one sample, until N samples total are written, N = POST (POST=0 or POST>DEPTH treated as DEPTH).
REQ-023 On the cycle the Nth sample is written, the FSM SHALL enter DONE and set done_flag.
REQ-024 A DATA read in DONE with LEVEL>0 SHALL return the oldest sample and decrement LEVEL by one.
REQ-025 A DATA read when LEVEL=0 or not in DONE SHALL return 0 and change no state.
REQ-026 Abort SHALL force IDLE from any state, flush the buffer and clear done_flag; abort and arm in the same write SHALL resolve as abort.
REQ-027 Writes to CTRL state bits and to THRESH/POST SHALL be accepted in any state; THRESH/POST changes made in CAPTURE SHALL take effect at the next arm.
REQ-028 LEVEL SHALL read the current buffer occupancy, 0..DEPTH.
REQ-029 The buffer SHALL never overflow; write and read pointers SHALL wrap modulo DEPTH.

Reset
REQ-030 Reset SHALL force: state IDLE, done_flag 0, irq_mask 0, THRESH 0, POST 0, LEVEL 0, pointers 0, d1/d2 0, readdata 0, irq 0.
REQ-031 Reset asserted mid-capture SHALL discard the capture; buffer contents SHALL be don't-care.

Configuration
REQ-032 With DDC_CAPTURE_TSTAMP_EN defined, a free-running 32-bit counter (reset 0, wraps) SHALL be latched into TSTAMP on the trigger cycle.
REQ-033 Without DDC_CAPTURE_TSTAMP_EN, address 6 SHALL read 0 and no counter SHALL be built.

Verification
REQ-034 THRESH=100, POST=4, arm, ramp in_port 96..110 -> DONE after 4 samples; DATA reads return 100,101,102,103, then 0; LEVEL 4->0.
REQ-035 IRQ_MASK=1, complete capture -> irq=1; CTRL write bit2 -> irq=0 next cycle.
REQ-036 POST=0 with DEPTH=64 -> exactly 64 samples captured, LEVEL=64, pointer wraps cleanly on readout.
REQ-037 Abort mid-CAPTURE -> state 0, LEVEL 0, no irq; arm+abort in one write -> IDLE.
REQ-038 in_port held at 200 with THRESH=100 -> no trigger (no crossing); drop to 50 then rise to 150 -> trigger at the rise.
REQ-039 With DDC_CAPTURE_TSTAMP_EN, trigger at cycle k after reset -> TSTAMP reads k (+/- fixed pipeline offset documented in the bench); without the macro, TSTAMP reads 0.
